// File: rtl/famicom_serial_responder.sv
// Emulates NUM_PADS daisy-chained Famicom/NES serial controllers answering the
// latch/pulse protocol from parallel button state held in the clk_sys domain.
module famicom_serial_responder #(
  parameter int   NUM_PADS     = 1,
  parameter int   BITS_PER_PAD = 8,
  parameter int   SYNC_STAGES  = 2,
  parameter logic FILL_BIT     = 1'b0,
  localparam int  TOTAL        = NUM_PADS * BITS_PER_PAD,
  localparam int  IDX_W        = $clog2(TOTAL + 1)
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 latch_in,
  input  logic                 pulse_in,
  input  logic [TOTAL-1:0]     pad_state,
  input  logic [NUM_PADS-1:0]  pad_enable,
  output logic                 data_out,
  output logic [IDX_W-1:0]     bit_index,
  output logic                 frame_strobe,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_EXHAUSTED} state_t;

  localparam logic [IDX_W-1:0] TOTAL_IDX = IDX_W'(TOTAL);

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0]  pulse_sync_q, pulse_sync_d;
  logic                    latch_dly_q, pulse_dly_q;
  logic [TOTAL-1:0]        pad_pipe_q [SYNC_STAGES];
  logic [TOTAL-1:0]        pad_pipe_d [SYNC_STAGES];
  logic [NUM_PADS-1:0]     en_pipe_q  [SYNC_STAGES];
  logic [NUM_PADS-1:0]     en_pipe_d  [SYNC_STAGES];
  logic [TOTAL-1:0]        sr_q, sr_d;
  logic [TOTAL-1:0]        load_image;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    overrun_q, overrun_d;
  logic                    frame_strobe_q, frame_strobe_d;
  logic                    latch_s, pulse_s, pulse_rise, latch_fall;

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
  assign pulse_rise = pulse_s & ~pulse_dly_q;
  assign latch_fall = ~latch_s & latch_dly_q;

  // Button state is delayed as deep as the latch synchroniser so a load sees
  // pad_state with the same latency as the protocol pins.
  always_comb begin
    latch_sync_d  = {latch_sync_q[SYNC_STAGES-2:0], latch_in};
    pulse_sync_d  = {pulse_sync_q[SYNC_STAGES-2:0], pulse_in};
    pad_pipe_d[0] = pad_state;
    en_pipe_d[0]  = pad_enable;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      pad_pipe_d[i] = pad_pipe_q[i-1];
      en_pipe_d[i]  = en_pipe_q[i-1];
    end
  end

  always_comb begin
    load_image = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (en_pipe_q[SYNC_STAGES-1][p])
        load_image[p*BITS_PER_PAD +: BITS_PER_PAD] =
          ~pad_pipe_q[SYNC_STAGES-1][p*BITS_PER_PAD +: BITS_PER_PAD];
    end
  end

  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    idx_d          = idx_q;
    overrun_d      = overrun_q;
    frame_strobe_d = latch_fall;
    if (latch_s) begin
      state_d   = ST_LOAD;
      sr_d      = load_image;
      idx_d     = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD, ST_SHIFT: begin
          if (pulse_rise) begin
            sr_d          = sr_q >> 1;
            sr_d[TOTAL-1] = FILL_BIT;
            idx_d         = idx_q + IDX_W'(1);
          end
          state_d = (idx_d == TOTAL_IDX) ? ST_EXHAUSTED : ST_SHIFT;
        end
        ST_EXHAUSTED: begin
          if (pulse_rise) overrun_d = 1'b1;
        end
        default: state_d = ST_SHIFT;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    pad_pipe_q <= pad_pipe_d;
    en_pipe_q  <= en_pipe_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q        <= ST_SHIFT;
      latch_sync_q   <= '0;
      pulse_sync_q   <= '0;
      latch_dly_q    <= 1'b0;
      pulse_dly_q    <= 1'b0;
      sr_q           <= {TOTAL{FILL_BIT}};
      idx_q          <= '0;
      overrun_q      <= 1'b0;
      frame_strobe_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      latch_sync_q   <= latch_sync_d;
      pulse_sync_q   <= pulse_sync_d;
      latch_dly_q    <= latch_s;
      pulse_dly_q    <= pulse_s;
      sr_q           <= sr_d;
      idx_q          <= idx_d;
      overrun_q      <= overrun_d;
      frame_strobe_q <= frame_strobe_d;
    end
  end

  assign data_out     = sr_q[0];
  assign bit_index    = idx_q;
  assign frame_strobe = frame_strobe_q;
  assign overrun      = overrun_q;
  assign busy         = (idx_q != '0) && (idx_q < TOTAL_IDX);

endmodule

// File: tb/tb_famicom_serial_responder.sv
// Directed bench for famicom_serial_responder with two 8-bit pads.
module tb_famicom_serial_responder;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        latch_in;
  logic        pulse_in;
  logic [15:0] pad_state;
  logic [1:0]  pad_enable;
  logic        data_out;
  logic [4:0]  bit_index;
  logic        frame_strobe;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;

  famicom_serial_responder #(
    .NUM_PADS(2), .BITS_PER_PAD(8), .SYNC_STAGES(2), .FILL_BIT(1'b0)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .latch_in(latch_in), .pulse_in(pulse_in),
    .pad_state(pad_state), .pad_enable(pad_enable), .data_out(data_out),
    .bit_index(bit_index), .frame_strobe(frame_strobe), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (frame_strobe === 1'b1) strobe_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic do_pulse();
    pulse_in = 1'b1;
    tick(4);
    pulse_in = 1'b0;
    tick(4);
  endtask

  task automatic do_latch();
    latch_in = 1'b1;
    tick(10);
    latch_in = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b1; latch_in = 1'b0; pulse_in = 1'b0;
    pad_state = 16'h0000; pad_enable = 2'b11;
    tick(3);
    checks++;
    if (data_out !== 1'b0 || bit_index !== 5'd0 || frame_strobe !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got data=%b idx=%0d fs=%b busy=%b ovr=%b, want 0 0 0 0 0",
               data_out, bit_index, frame_strobe, busy, overrun);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp_bits = 16'hFF7E;
    int s0;
    pad_state = 16'h0081; pad_enable = 2'b11;
    s0 = strobe_cnt;
    do_latch();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data_out !== exp_bits[i]) begin
        errors++;
        $display("FAIL basic_bit%0d: got %b want %b", i, data_out, exp_bits[i]);
      end
      do_pulse();
      checks++;
      if (bit_index !== 5'(i + 1) || busy !== (i < 15)) begin
        errors++;
        $display("FAIL basic_idx%0d: got idx=%0d busy=%b want idx=%0d busy=%b",
                 i, bit_index, busy, i + 1, (i < 15));
      end
    end
    checks++;
    if (strobe_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL basic_strobe_count: got %0d want 1", strobe_cnt - s0);
    end
    checks++;
    if (overrun !== 1'b0 || data_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: got ovr=%b data=%b want 0 0", overrun, data_out);
    end
  endtask

  task automatic test_overrun();
    do_pulse();
    do_pulse();
    checks++;
    if (data_out !== 1'b0 || bit_index !== 5'd16 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got data=%b idx=%0d ovr=%b want 0 16 1",
               data_out, bit_index, overrun);
    end
    latch_in = 1'b1;
    tick(5);
    checks++;
    if (overrun !== 1'b0 || bit_index !== 5'd0) begin
      errors++;
      $display("FAIL overrun_clear: got ovr=%b idx=%0d want 0 0", overrun, bit_index);
    end
    latch_in = 1'b0;
    tick(4);
  endtask

  task automatic test_disabled_pad();
    pad_state = 16'hFF00; pad_enable = 2'b01;
    do_latch();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data_out !== 1'b1) begin
        errors++;
        $display("FAIL disabled_bit%0d: got %b want 1", i, data_out);
      end
      do_pulse();
    end
    pad_enable = 2'b11;
  endtask

  task automatic test_latch_held();
    int s0;
    pad_state = 16'h0000;
    s0 = strobe_cnt;
    latch_in = 1'b1;
    tick(6);
    checks++;
    if (data_out !== 1'b1) begin
      errors++;
      $display("FAIL held_initial: got %b want 1", data_out);
    end
    pad_state = 16'h0001;
    tick(2);
    checks++;
    if (data_out !== 1'b1) begin
      errors++;
      $display("FAIL held_latency_early: got %b want 1", data_out);
    end
    tick(1);
    checks++;
    if (data_out !== 1'b0) begin
      errors++;
      $display("FAIL held_follow_pressed: got %b want 0", data_out);
    end
    pad_state = 16'h0000;
    tick(3);
    checks++;
    if (data_out !== 1'b1) begin
      errors++;
      $display("FAIL held_follow_released: got %b want 1", data_out);
    end
    do_pulse(); do_pulse(); do_pulse();
    checks++;
    if (bit_index !== 5'd0 || strobe_cnt != s0 || data_out !== 1'b1) begin
      errors++;
      $display("FAIL held_pulses: got idx=%0d strobes=%0d data=%b want 0 0 1",
               bit_index, strobe_cnt - s0, data_out);
    end
    latch_in = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] exp_bits = 16'hC35A;
    pad_state = 16'h3CA5;
    do_latch();
    for (int i = 0; i < 5; i++) do_pulse();
    checks++;
    if (bit_index !== 5'd5) begin
      errors++;
      $display("FAIL midframe_idx: got %0d want 5", bit_index);
    end
    reset = 1'b1;
    tick(1);
    checks++;
    if (data_out !== 1'b0 || bit_index !== 5'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got data=%b idx=%0d busy=%b ovr=%b want 0 0 0 0",
               data_out, bit_index, busy, overrun);
    end
    reset = 1'b0;
    tick(2);
    do_latch();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (data_out !== exp_bits[i]) begin
        errors++;
        $display("FAIL refresh_bit%0d: got %b want %b", i, data_out, exp_bits[i]);
      end
      do_pulse();
    end
  endtask

  task automatic test_simultaneous();
    pad_state = 16'h0002;
    latch_in = 1'b1;
    tick(6);
    checks++;
    if (data_out !== 1'b1) begin
      errors++;
      $display("FAIL simul_bit0: got %b want 1", data_out);
    end
    latch_in = 1'b0;
    pulse_in = 1'b1;
    tick(2);
    checks++;
    if (frame_strobe !== 1'b0 || bit_index !== 5'd0) begin
      errors++;
      $display("FAIL simul_early: got fs=%b idx=%0d want 0 0", frame_strobe, bit_index);
    end
    tick(1);
    checks++;
    if (frame_strobe !== 1'b1 || bit_index !== 5'd1 || data_out !== 1'b0) begin
      errors++;
      $display("FAIL simul_edge: got fs=%b idx=%0d data=%b want 1 1 0",
               frame_strobe, bit_index, data_out);
    end
    tick(1);
    checks++;
    if (frame_strobe !== 1'b0 || bit_index !== 5'd1) begin
      errors++;
      $display("FAIL simul_after: got fs=%b idx=%0d want 0 1", frame_strobe, bit_index);
    end
    pulse_in = 1'b0;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_disabled_pad();
    test_latch_held();
    test_reset_mid_frame();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
